// File: rtl/beacon_pkg.sv
// Shared types for the beacon flag supervisor.
// Channel encoding and sequencer states.
package beacon_pkg;

  typedef enum logic [1:0] {
    CH_PV    = 2'd0,
    CH_CAP   = 2'd1,
    CH_LIGHT = 2'd2
  } adc_chan_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EVAL = 2'd2
  } sup_state_t;

  function automatic adc_chan_t next_chan(adc_chan_t c);
    adc_chan_t n;
    n = CH_PV;
    unique case (c)
      CH_PV:   n = CH_CAP;
      CH_CAP:  n = CH_LIGHT;
      default: n = CH_PV;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/beacon_flag_supervisor_if.sv
// ADC request/response bundle between the supervisor and the ADC.
// Supervisor is master (drives req/chan), ADC is slave.
interface beacon_flag_supervisor_if #(
  parameter int ADC_W = 12
);
  logic             adc_req;
  logic [1:0]       adc_chan;
  logic             adc_valid;
  logic [ADC_W-1:0] adc_data;

  modport master (
    output adc_req,
    output adc_chan,
    input  adc_valid,
    input  adc_data
  );

  modport slave (
    input  adc_req,
    input  adc_chan,
    output adc_valid,
    output adc_data
  );
endinterface

// File: rtl/hyst_debounce.sv
// Hysteresis comparator with N-sample debounce on a registered flag.
// Exposes the next-state flag for downstream registered logic.
module hyst_debounce #(
  parameter int unsigned W       = 12,
  parameter int unsigned SET     = 0,
  parameter int unsigned CLR     = 0,
  parameter bit          ABOVE   = 1'b1,
  parameter int unsigned DEB_N   = 4,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         flag_o,
  output logic         flag_d_o
);

  localparam int unsigned CW = $clog2(DEB_N + 1);
  localparam logic [W-1:0]  SET_V = W'(SET);
  localparam logic [W-1:0]  CLR_V = W'(CLR);
  localparam logic [CW-1:0] LAST  = CW'(DEB_N - 1);

  logic          flag_q, flag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          set_c, clr_c, opp;

  always_comb begin
    if (ABOVE) begin
      set_c = val_i >= SET_V;
      clr_c = val_i < CLR_V;
    end else begin
      set_c = val_i <= SET_V;
      clr_c = val_i > CLR_V;
    end
    opp    = flag_q ? clr_c : set_c;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (en_i) begin
      if (!opp) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        flag_d = ~flag_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign flag_o   = flag_q;
  assign flag_d_o = flag_d;

endmodule

// File: rtl/beacon_flag_supervisor.sv
// Round-robin ADC sequencer feeding debounced power flags to the beacon FSM.
// Fails safe: low-power asserted on reset and on any ADC timeout.
module beacon_flag_supervisor
  import beacon_pkg::*;
#(
  parameter int unsigned ADC_W        = 12,
  parameter int unsigned DEB_N        = 4,
  parameter int unsigned PERIOD_CYC   = 50000,
  parameter int unsigned TIMEOUT_CYC  = 256,
  parameter int unsigned PV_HI_SET    = 3000,
  parameter int unsigned PV_HI_CLR    = 2800,
  parameter int unsigned PV_MIN_SET   = 1000,
  parameter int unsigned PV_MIN_CLR   = 1200,
  parameter int unsigned CAP_FULL_SET = 3900,
  parameter int unsigned CAP_FULL_CLR = 3700,
  parameter int unsigned CAP_5V_SET   = 2050,
  parameter int unsigned CAP_5V_CLR   = 1950,
  parameter int unsigned DARK_SET     = 300,
  parameter int unsigned DARK_CLR     = 800
) (
  input  logic clk,
  input  logic rst,
  beacon_flag_supervisor_if.master adc,
  output logic cap_charged,
  output logic cap_over5,
  output logic pv_power_high,
  output logic lights_on_flag,
  output logic low_power1,
  output logic low_power2,
  output logic flags_valid,
  output logic adc_fault
);

  localparam int unsigned PW = $clog2(PERIOD_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] PLAST = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  sup_state_t       state_q, state_d;
  adc_chan_t        chan_q, chan_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [ADC_W-1:0] smp_q, smp_d;
  logic             fv_q, fv_d;
  logic             fault_q, fault_d;
  logic             req_q, lp1_q, lp2_q;
  logic             en_pv, en_cap, en_lt;
  logic             pv_low, pv_low_d, c5_d;
  logic [2:0]       flag_d_unused;

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    pcnt_d  = '0;
    tcnt_d  = '0;
    smp_d   = smp_q;
    fv_d    = fv_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (pcnt_q == PLAST) begin
          state_d = CONV;
          chan_d  = CH_PV;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      CONV: begin
        // a strobe on the expiry cycle still counts as a good sample
        if (adc.adc_valid) begin
          smp_d   = adc.adc_data;
          state_d = EVAL;
        end else if (tcnt_q == TLAST) begin
          fault_d = 1'b1;
          if (chan_q == CH_LIGHT) state_d = IDLE;
          else chan_d = next_chan(chan_q);
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      EVAL: begin
        if (chan_q == CH_LIGHT) begin
          state_d = IDLE;
          fv_d    = 1'b1;
        end else begin
          state_d = CONV;
          chan_d  = next_chan(chan_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CONV;
      chan_q  <= CH_PV;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      smp_q   <= '0;
      fv_q    <= 1'b0;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
      lp1_q   <= 1'b1;
      lp2_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      smp_q   <= smp_d;
      fv_q    <= fv_d;
      fault_q <= fault_d;
      req_q   <= state_d == CONV;
      lp1_q   <= (pv_low_d & ~c5_d) | fault_d;
      lp2_q   <= pv_low_d | fault_d;
    end
  end

  assign en_pv  = (state_q == EVAL) && (chan_q == CH_PV);
  assign en_cap = (state_q == EVAL) && (chan_q == CH_CAP);
  assign en_lt  = (state_q == EVAL) && (chan_q == CH_LIGHT);

  hyst_debounce #(
    .W(ADC_W), .SET(PV_HI_SET), .CLR(PV_HI_CLR),
    .ABOVE(1'b1), .DEB_N(DEB_N), .RST_VAL(1'b0)
  ) u_pv_high (
    .clk(clk), .rst(rst), .en_i(en_pv), .val_i(smp_q),
    .flag_o(pv_power_high), .flag_d_o(flag_d_unused[0])
  );

  hyst_debounce #(
    .W(ADC_W), .SET(PV_MIN_SET), .CLR(PV_MIN_CLR),
    .ABOVE(1'b0), .DEB_N(DEB_N), .RST_VAL(1'b1)
  ) u_pv_low (
    .clk(clk), .rst(rst), .en_i(en_pv), .val_i(smp_q),
    .flag_o(pv_low), .flag_d_o(pv_low_d)
  );

  hyst_debounce #(
    .W(ADC_W), .SET(CAP_FULL_SET), .CLR(CAP_FULL_CLR),
    .ABOVE(1'b1), .DEB_N(DEB_N), .RST_VAL(1'b0)
  ) u_cap_full (
    .clk(clk), .rst(rst), .en_i(en_cap), .val_i(smp_q),
    .flag_o(cap_charged), .flag_d_o(flag_d_unused[1])
  );

  hyst_debounce #(
    .W(ADC_W), .SET(CAP_5V_SET), .CLR(CAP_5V_CLR),
    .ABOVE(1'b1), .DEB_N(DEB_N), .RST_VAL(1'b0)
  ) u_cap_5v (
    .clk(clk), .rst(rst), .en_i(en_cap), .val_i(smp_q),
    .flag_o(cap_over5), .flag_d_o(c5_d)
  );

  hyst_debounce #(
    .W(ADC_W), .SET(DARK_SET), .CLR(DARK_CLR),
    .ABOVE(1'b0), .DEB_N(DEB_N), .RST_VAL(1'b0)
  ) u_dark (
    .clk(clk), .rst(rst), .en_i(en_lt), .val_i(smp_q),
    .flag_o(lights_on_flag), .flag_d_o(flag_d_unused[2])
  );

  logic pv_low_unused;
  assign pv_low_unused = pv_low;

  assign adc.adc_req  = req_q;
  assign adc.adc_chan = chan_q;
  assign low_power1   = lp1_q;
  assign low_power2   = lp2_q;
  assign flags_valid  = fv_q;
  assign adc_fault    = fault_q;

endmodule
